laser_scheduler: RTL and testbench
==================================

Name: laser_scheduler

Overview:
- Shares one laser emitter between NUM_REQ game-logic requesters.
- Round-robin arbitration; the winner gets one fixed-length ON burst, then a mandatory cooldown.
- Sits between the game/hit logic and the emitter pin.
- Replaces per-requester free-running cooldown counters with one sequenced, arbitrated timer.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- ON_CYCLES, 100000000, laser-on duration in clock cycles (>=1).
- OFF_CYCLES, 100000000, cooldown duration in clock cycles (>=1).
- CNT_W, 32, duration counter width; must hold max(ON_CYCLES, OFF_CYCLES)-1.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  level fire requests; a requester holds its bit until it sees its grant.
- grant  out  NUM_REQ  one-hot, one-cycle pulse to the winner.
- owner  out  $clog2(NUM_REQ)  index of the last winner; held stable through ON and COOLDOWN.
- laser_on  out  1  emitter drive, active-high.
- busy  out  1  high in ON and COOLDOWN.
- done  out  1  one-cycle pulse on the last ON cycle.
- abort  in  1  only present with the optional feature.

Behaviour:
- Reset (synchronous, active-high; takes priority over everything):
  - state=IDLE, cnt=0, rr_ptr=0, owner=0.
  - grant, laser_on, busy, done all 0.
  - Reset asserted mid-ON: laser_on is 0 in the cycle after the sampling edge.
- States: IDLE, ON, COOLDOWN.
- IDLE, req==0: stay in IDLE.
- IDLE, req!=0: pick the first set bit searching upward from rr_ptr, wrapping modulo NUM_REQ. On that edge:
  - state<=ON, cnt<=0, laser_on<=1, busy<=1.
  - grant<=onehot(winner), owner<=winner, rr_ptr<=(winner+1) mod NUM_REQ.
  - Latency: req sampled at edge k, so grant and laser_on are visible from edge k+1.
  - grant is high for exactly one cycle.
- ON:
  - cnt increments each cycle.
  - done=1 during the cycle where cnt==ON_CYCLES-1.
  - At the edge ending that cycle: state<=COOLDOWN, cnt<=0, laser_on<=0.
  - laser_on is high for exactly ON_CYCLES cycles.
- COOLDOWN:
  - laser_on=0, busy=1.
  - After OFF_CYCLES cycles: state<=IDLE, busy<=0.
- IDLE arbitration takes one cycle. The minimum gap from laser_on falling to the next laser_on rising is OFF_CYCLES+1 cycles.
- req is ignored in ON/COOLDOWN. Requests are not queued: a bit dropped before IDLE is lost.
- Only one grant per IDLE cycle; simultaneous requests are resolved purely by rr_ptr.
- cnt never wraps: its compare value is a parameter, and elaboration fails if the parameter exceeds 2**CNT_W-1.
- A parameter of 0 is illegal; a sim-only assertion fires at time 0.

Optional Feature:
- Macro: LASER_SCHED_ABORT_EN.
- Defined:
  - The abort port exists.
  - abort=1 sampled in ON: the next edge forces state<=COOLDOWN, cnt<=0, laser_on<=0, and done pulses in that sampled cycle.
  - Cooldown is still the full OFF_CYCLES.
  - abort is ignored in IDLE and COOLDOWN.
- Undefined:
  - No abort port.
  - The ON burst always runs the full ON_CYCLES.

Decomposition:
- Package laser_pkg:
  - state enum laser_state_t {IDLE, ON, COOLDOWN}.
  - CLK_HZ=50000000.
  - Default durations LASER_ON_CYCLES and LASER_OFF_CYCLES.
- Sub-module rr_arbiter (parameter NUM_REQ):
  - Inputs: req, rr_ptr.
  - Outputs: valid, winner index, onehot.
  - Purely combinational; rr_ptr is stored in laser_scheduler.

Test Plan (NUM_REQ=4, ON_CYCLES=4, OFF_CYCLES=3):
- Single request: req=4'b0100 held from the cycle after reset release -> next cycle grant=4'b0100 (1 cycle), owner=2, laser_on high 4 cycles, done on the 4th, busy high 7 cycles, then IDLE.
- Fairness: req=4'b1111 held continuously -> grants in order 0,1,2,3,0; laser_on rising edges 8 cycles apart (4+3+1).
- Wrap-around: grant to 3 via req=4'b1000, then req=4'b1001 -> next grant to 0 (rr_ptr wraps to 0).
- Dropped request: req[1] pulsed for 2 cycles during requester 0's ON, none in IDLE -> no grant[1]; IDLE holds with laser_on=0.
- Reset mid-ON: reset asserted in ON cycle 2 -> next cycle laser_on=0, busy=0, grant=0, owner=0; after release, req=4'b1111 grants 0 first.
- Abort (with LASER_SCHED_ABORT_EN): abort=1 in ON cycle 2 -> done that cycle, laser_on low next cycle, cooldown exactly 3 cycles. Without the macro: the full 4-cycle burst runs and the abort port is absent.

Source files
------------

// File: rtl/laser_pkg.sv
// Purpose : shared state encoding and default timing for the laser scheduler.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package laser_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ON       = 2'd1,
    COOLDOWN = 2'd2
  } laser_state_t;

  localparam int CLK_HZ = 50000000;

  // Two seconds of emitter-on time followed by two seconds of cooldown.
  localparam int LASER_ON_CYCLES  = 2 * CLK_HZ;
  localparam int LASER_OFF_CYCLES = 2 * CLK_HZ;

endpackage

// File: rtl/rr_arbiter.sv
// Purpose : round-robin pick of the first set req bit at or above rr_ptr, wrapping.
// Latency : purely combinational, zero cycles.
// Backpressure: none; the caller decides when a pick is consumed and advances rr_ptr.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   winner,
  output logic [NUM_REQ-1:0] onehot
);

  // Walk the requesters starting at rr_ptr; the first set bit wins.
  always_comb begin
    int k;
    valid  = 1'b0;
    winner = '0;
    k      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = int'(rr_ptr) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (!valid && req[k[IDX_W-1:0]]) begin
        valid  = 1'b1;
        winner = k[IDX_W-1:0];
      end
    end
  end

  assign onehot = valid ? (NUM_REQ'(1) << winner) : '0;

endmodule

// File: rtl/laser_scheduler.sv
// Purpose : shares one laser emitter between NUM_REQ requesters; round-robin grant, fixed ON burst, cooldown.
// Latency : req sampled at edge k gives grant/laser_on from edge k+1; burst ON_CYCLES, cooldown OFF_CYCLES.
// Backpressure: req ignored while busy and never queued; requesters hold req until they see grant.
// Optional: define LASER_SCHED_ABORT_EN to add the abort input that cuts an ON burst short.
module laser_scheduler
  import laser_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int ON_CYCLES  = LASER_ON_CYCLES,
  parameter  int OFF_CYCLES = LASER_OFF_CYCLES,
  parameter  int CNT_W      = 32,
  localparam int IDX_W      = $clog2(NUM_REQ)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   owner,
  output logic               laser_on,
  output logic               busy,
  output logic               done
`ifdef LASER_SCHED_ABORT_EN
  ,
  input  logic               abort
`endif
);

  // Illegal configurations are rejected at elaboration rather than silently wrapping.
  localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

  if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
    $error("laser_scheduler: NUM_REQ must be in 2..16");
  end
  if (ON_CYCLES < 1 || OFF_CYCLES < 1) begin : g_bad_zero
    $error("laser_scheduler: ON_CYCLES and OFF_CYCLES must be at least 1");
  end
  if (CNT_W < 1 || CNT_W > 62) begin : g_bad_cnt_w
    $error("laser_scheduler: CNT_W must be in 1..62");
  end
  if (longint'(ON_CYCLES) > CNT_MAX || longint'(OFF_CYCLES) > CNT_MAX) begin : g_bad_range
    $error("laser_scheduler: duration does not fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYCLES - 1);

  laser_state_t       state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_d;
  logic [IDX_W-1:0]   owner_d;
  logic [NUM_REQ-1:0] grant_d;
  logic               laser_on_d;
  logic               busy_d;
  logic               abort_hit;

  logic               arb_valid;
  logic [IDX_W-1:0]   arb_winner;
  logic [NUM_REQ-1:0] arb_onehot;

`ifdef LASER_SCHED_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req    (req),
    .rr_ptr (rr_ptr),
    .valid  (arb_valid),
    .winner (arb_winner),
    .onehot (arb_onehot)
  );

  // Next-state and next-output decode; done is the only combinational output.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    rr_ptr_d   = rr_ptr;
    owner_d    = owner;
    grant_d    = '0;
    laser_on_d = laser_on;
    busy_d     = busy;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (arb_valid) begin
          state_d    = ON;
          cnt_d      = '0;
          laser_on_d = 1'b1;
          busy_d     = 1'b1;
          grant_d    = arb_onehot;
          owner_d    = arb_winner;
          rr_ptr_d   = (arb_winner == IDX_W'(NUM_REQ - 1)) ? '0 : arb_winner + 1'b1;
        end
      end
      ON: begin
        if (cnt == ON_LAST || abort_hit) begin
          done       = 1'b1;
          state_d    = COOLDOWN;
          cnt_d      = '0;
          laser_on_d = 1'b0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      COOLDOWN: begin
        if (cnt == OFF_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: begin
        state_d    = IDLE;
        cnt_d      = '0;
        laser_on_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset forces the emitter off on the very next cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      rr_ptr   <= '0;
      owner    <= '0;
      grant    <= '0;
      laser_on <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      rr_ptr   <= rr_ptr_d;
      owner    <= owner_d;
      grant    <= grant_d;
      laser_on <= laser_on_d;
      busy     <= busy_d;
    end
  end

endmodule

// File: tb/tb_laser_scheduler.sv
// Purpose : directed self-checking bench for laser_scheduler (NUM_REQ=4, ON=4, OFF=3).
// Latency : inputs driven 1 time unit after posedge, outputs sampled at the same point.
// Backpressure: n/a.
module tb_laser_scheduler;

  localparam int NUM_REQ = 4;
  localparam int ON_C    = 4;
  localparam int OFF_C   = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req   = 4'b0000;
  logic [3:0] grant;
  logic [1:0] owner;
  logic       laser_on;
  logic       busy;
  logic       done;
`ifdef LASER_SCHED_ABORT_EN
  logic       abort = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  int t0     = 0;
  int exp_idx [5] = '{0, 1, 2, 3, 0};
  logic [3:0] seen;

  laser_scheduler #(
    .NUM_REQ    (NUM_REQ),
    .ON_CYCLES  (ON_C),
    .OFF_CYCLES (OFF_C),
    .CNT_W      (8)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .req      (req),
    .grant    (grant),
    .owner    (owner),
    .laser_on (laser_on),
    .busy     (busy),
    .done     (done)
`ifdef LASER_SCHED_ABORT_EN
    ,
    .abort    (abort)
`endif
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycle <= cycle + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its summary within the time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_grant(input string tag);
    int n;
    n = 0;
    while (grant == 4'b0000 && n < 40) begin
      tick();
      n++;
    end
    check({tag, " grant timeout"}, 32'(grant != 4'b0000), 32'd1);
  endtask

  initial begin
    // Reset state.
    reset = 1'b1;
    tick();
    tick();
    check("rst grant",    32'(grant),    32'h0);
    check("rst owner",    32'(owner),    32'h0);
    check("rst laser_on", 32'(laser_on), 32'h0);
    check("rst busy",     32'(busy),     32'h0);
    check("rst done",     32'(done),     32'h0);

    // Single request from requester 2.
    reset = 1'b0;
    req   = 4'b0100;
    tick();
    req = 4'b0000;
    for (int i = 0; i < ON_C; i++) begin
      check("single laser_on", 32'(laser_on), 32'h1);
      check("single busy",     32'(busy),     32'h1);
      check("single owner",    32'(owner),    32'h2);
      check("single done",     32'(done),     32'(i == ON_C - 1));
      check("single grant",    32'(grant),    (i == 0) ? 32'h4 : 32'h0);
      tick();
    end
    for (int i = 0; i < OFF_C; i++) begin
      check("single cool laser_on", 32'(laser_on), 32'h0);
      check("single cool busy",     32'(busy),     32'h1);
      check("single cool done",     32'(done),     32'h0);
      tick();
    end
    check("single idle busy",  32'(busy),  32'h0);
    check("single idle owner", 32'(owner), 32'h2);

    // Wrap-around: grant 3, then 1001 must go to 0.
    req = 4'b1000;
    wait_grant("wrap3");
    check("wrap3 grant", 32'(grant), 32'h8);
    check("wrap3 owner", 32'(owner), 32'h3);
    t0  = cycle;
    req = 4'b1001;
    tick();
    wait_grant("wrap0");
    check("wrap0 grant",   32'(grant),  32'h1);
    check("wrap0 owner",   32'(owner),  32'h0);
    check("wrap0 spacing", 32'(cycle - t0), 32'd8);

    // Dropped request: req[1] pulsed for two cycles inside requester 0's burst.
    req = 4'b0000;
    tick();
    req = 4'b0010;
    tick();
    tick();
    req  = 4'b0000;
    seen = 4'b0000;
    for (int i = 0; i < 12; i++) begin
      tick();
      seen = seen | grant;
    end
    check("drop no grant", 32'(seen),     32'h0);
    check("drop laser_on", 32'(laser_on), 32'h0);
    check("drop busy",     32'(busy),     32'h0);
    check("drop owner",    32'(owner),    32'h0);

    // Reset in ON cycle 2 of a burst owned by requester 2.
    req = 4'b0100;
    wait_grant("rst_on");
    check("rst_on owner", 32'(owner), 32'h2);
    req = 4'b0000;
    tick();
    check("rst_on pre laser_on", 32'(laser_on), 32'h1);
    reset = 1'b1;
    tick();
    check("rst_on laser_on", 32'(laser_on), 32'h0);
    check("rst_on busy",     32'(busy),     32'h0);
    check("rst_on grant",    32'(grant),    32'h0);
    check("rst_on owner0",   32'(owner),    32'h0);
    reset = 1'b0;

    // Fairness with all requesters active; first grant proves rr_ptr was cleared.
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant("fair");
      check("fair grant",    32'(grant),    32'(1) << exp_idx[k]);
      check("fair owner",    32'(owner),    32'(exp_idx[k]));
      check("fair laser_on", 32'(laser_on), 32'h1);
      if (k > 0) check("fair spacing", 32'(cycle - t0), 32'd8);
      t0 = cycle;
      tick();
    end
    req = 4'b0000;

    // Now in ON cycle 2 of requester 0's burst.
`ifdef LASER_SCHED_ABORT_EN
    abort = 1'b1;
    #1;
    check("abort done",     32'(done),     32'h1);
    check("abort laser_on", 32'(laser_on), 32'h1);
    tick();
    abort = 1'b0;
    check("abort cut laser_on", 32'(laser_on), 32'h0);
`else
    for (int i = 2; i <= ON_C; i++) begin
      check("full laser_on", 32'(laser_on), 32'h1);
      check("full done",     32'(done),     32'(i == ON_C));
      tick();
    end
`endif
    for (int i = 0; i < OFF_C; i++) begin
      check("tail cool laser_on", 32'(laser_on), 32'h0);
      check("tail cool busy",     32'(busy),     32'h1);
      tick();
    end
    check("tail idle busy",  32'(busy),  32'h0);
    check("tail idle grant", 32'(grant), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
